// File: rtl/riscv_pkg.sv
// Shared RV32I opcode constants, selector/state enums and decode helpers
// used by the hazard unit.
package riscv_pkg;

    localparam logic [6:0] OP     = 7'b0110011;
    localparam logic [6:0] OP_IMM = 7'b0010011;
    localparam logic [6:0] LOAD   = 7'b0000011;
    localparam logic [6:0] STORE  = 7'b0100011;
    localparam logic [6:0] BRANCH = 7'b1100011;
    localparam logic [6:0] JAL    = 7'b1101111;
    localparam logic [6:0] JALR   = 7'b1100111;
    localparam logic [6:0] LUI    = 7'b0110111;
    localparam logic [6:0] AUIPC  = 7'b0010111;

    typedef enum logic [1:0] {
        FWD_RF = 2'b00,
        FWD_P1 = 2'b01,
        FWD_P2 = 2'b10
    } fwd_sel_e;

    typedef enum logic [1:0] {
        RUN   = 2'd0,
        STALL = 2'd1,
        FLUSH = 2'd2
    } hz_state_e;

    function automatic logic uses_rs1(input logic [6:0] op);
        return !(op == LUI || op == AUIPC || op == JAL);
    endfunction

    function automatic logic uses_rs2(input logic [6:0] op);
        return op == OP || op == STORE || op == BRANCH;
    endfunction

    function automatic logic writes_rd(input logic [6:0] op,
                                       input logic       reg_write,
                                       input logic [4:0] rd);
        return reg_write && rd != 5'd0 && op != STORE && op != BRANCH;
    endfunction

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with synchronous active-low clear.
module sat_counter #(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         en,
    output logic [W-1:0] count
);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            count <= '0;
        end else if (en && count != '1) begin
            count <= count + 1'b1;
        end
    end

endmodule

// File: rtl/hazard_unit.sv
// Two-source RAW forwarding with multi-cycle load-use stalls,
// multi-cycle branch flushes and saturating perf counters.
module hazard_unit
    import riscv_pkg::*;
#(
    parameter int LOAD_USE_CYCLES = 1,
    parameter int FLUSH_CYCLES    = 1,
    parameter int FWD_EN          = 1,
    parameter int CNT_W           = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [31:0]      c_instr,
    input  logic [31:0]      p1_instr,
    input  logic             p1_reg_write,
    input  logic [31:0]      p2_instr,
    input  logic             p2_reg_write,
    input  logic             br_taken,
    output logic [1:0]       fwd_a,
    output logic [1:0]       fwd_b,
    output logic             stall,
    output logic             flush,
    output logic [CNT_W-1:0] stall_count,
    output logic [CNT_W-1:0] flush_count
);

    localparam logic [3:0] LU_INIT = 4'(LOAD_USE_CYCLES - 1);
    localparam logic [3:0] FL_INIT = 4'(FLUSH_CYCLES - 1);

    hz_state_e  state;
    logic [3:0] cnt;

    logic [6:0] c_op;
    logic [4:0] c_rs1, c_rs2, p1_rd, p2_rd;
    logic       p1_ok, p2_ok, p1_load;
    logic       a1, a2, b1, b2;
    logic       hazard;
    fwd_sel_e   run_a, run_b;
    logic       unused_bits;

    assign c_op  = c_instr[6:0];
    assign c_rs1 = c_instr[19:15];
    assign c_rs2 = c_instr[24:20];
    assign p1_rd = p1_instr[11:7];
    assign p2_rd = p2_instr[11:7];

    assign unused_bits = ^{c_instr[31:25], c_instr[14:7],
                           p1_instr[31:12], p2_instr[31:12]};

    assign p1_ok   = writes_rd(p1_instr[6:0], p1_reg_write, p1_rd);
    assign p2_ok   = writes_rd(p2_instr[6:0], p2_reg_write, p2_rd);
    assign p1_load = p1_instr[6:0] == LOAD;

    assign a1 = p1_ok && uses_rs1(c_op) && p1_rd == c_rs1;
    assign a2 = p2_ok && uses_rs1(c_op) && p2_rd == c_rs1;
    assign b1 = p1_ok && uses_rs2(c_op) && p1_rd == c_rs2;
    assign b2 = p2_ok && uses_rs2(c_op) && p2_rd == c_rs2;

    // A P1 load match neither forwards nor falls back to the stale P2 value.
    always_comb begin
        run_a  = FWD_RF;
        run_b  = FWD_RF;
        hazard = 1'b0;
        if (FWD_EN != 0) begin
            if (a1)      run_a = p1_load ? FWD_RF : FWD_P1;
            else if (a2) run_a = FWD_P2;
            if (b1)      run_b = p1_load ? FWD_RF : FWD_P1;
            else if (b2) run_b = FWD_P2;
            hazard = p1_load && (a1 || b1);
        end else begin
            hazard = a1 || a2 || b1 || b2;
        end
    end

    always_comb begin
        fwd_a = FWD_RF;
        fwd_b = FWD_RF;
        stall = 1'b0;
        flush = 1'b0;
        if (rst_n) begin
            unique case (state)
                RUN: begin
                    if (br_taken) flush = 1'b1;
                    else          stall = hazard;
                    fwd_a = run_a;
                    fwd_b = run_b;
                end
                STALL: begin
                    if (br_taken) flush = 1'b1;
                    else          stall = 1'b1;
                end
                FLUSH:   flush = 1'b1;
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= RUN;
            cnt   <= '0;
        end else begin
            unique case (state)
                RUN: begin
                    if (br_taken) begin
                        if (FLUSH_CYCLES > 1) begin
                            state <= FLUSH;
                            cnt   <= FL_INIT;
                        end
                    end else if (hazard && LOAD_USE_CYCLES > 1) begin
                        state <= STALL;
                        cnt   <= LU_INIT;
                    end
                end
                STALL: begin
                    if (br_taken) begin
                        state <= (FLUSH_CYCLES > 1) ? FLUSH : RUN;
                        cnt   <= (FLUSH_CYCLES > 1) ? FL_INIT : 4'd0;
                    end else if (cnt == 4'd1) begin
                        state <= RUN;
                        cnt   <= '0;
                    end else begin
                        cnt <= cnt - 4'd1;
                    end
                end
                FLUSH: begin
                    if (br_taken) begin
                        cnt <= FL_INIT;
                    end else if (cnt == 4'd1) begin
                        state <= RUN;
                        cnt   <= '0;
                    end else begin
                        cnt <= cnt - 4'd1;
                    end
                end
                default: begin
                    state <= RUN;
                    cnt   <= '0;
                end
            endcase
        end
    end

    sat_counter #(.W(CNT_W)) u_stall_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .en    (stall),
        .count (stall_count)
    );

    sat_counter #(.W(CNT_W)) u_flush_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .en    (flush),
        .count (flush_count)
    );

endmodule

// File: tb/tb_hazard_unit.sv
// Three parameterisations of hazard_unit driven in lockstep, checked
// against a cycle-count reference model plus directed scenarios.
module tb_hazard_unit;

    localparam int LU[3] = '{2, 3, 2};
    localparam int FL[3] = '{2, 1, 3};
    localparam int FW[3] = '{1, 1, 0};
    localparam int CW[3] = '{16, 16, 4};

    localparam logic [31:0] ADD   = 32'h002081B3;
    localparam logic [31:0] ADDI1 = 32'h00500093;
    localparam logic [31:0] ADDI2 = 32'h00500113;
    localparam logic [31:0] ADDI0 = 32'h00500013;
    localparam logic [31:0] LW1   = 32'h00002083;
    localparam logic [31:0] NOP   = 32'h00000013;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [31:0] c_instr, p1_instr, p2_instr;
    logic        p1_reg_write, p2_reg_write, br_taken;

    logic [1:0]  fa[3], fb[3];
    logic        st[3], fl[3];
    logic [15:0] sc[3], fc[3];
    logic [3:0]  sc_c, fc_c;

    int checks = 0;
    int errors = 0;

    int rem_s[3], rem_f[3], ms[3], mf[3];
    bit e_st[3], e_fl[3], e_hz[3];

    always #5 clk = ~clk;

    hazard_unit #(.LOAD_USE_CYCLES(2), .FLUSH_CYCLES(2),
                  .FWD_EN(1), .CNT_W(16)) u_a (
        .clk(clk), .rst_n(rst_n), .c_instr(c_instr),
        .p1_instr(p1_instr), .p1_reg_write(p1_reg_write),
        .p2_instr(p2_instr), .p2_reg_write(p2_reg_write),
        .br_taken(br_taken), .fwd_a(fa[0]), .fwd_b(fb[0]),
        .stall(st[0]), .flush(fl[0]),
        .stall_count(sc[0]), .flush_count(fc[0])
    );

    hazard_unit #(.LOAD_USE_CYCLES(3), .FLUSH_CYCLES(1),
                  .FWD_EN(1), .CNT_W(16)) u_b (
        .clk(clk), .rst_n(rst_n), .c_instr(c_instr),
        .p1_instr(p1_instr), .p1_reg_write(p1_reg_write),
        .p2_instr(p2_instr), .p2_reg_write(p2_reg_write),
        .br_taken(br_taken), .fwd_a(fa[1]), .fwd_b(fb[1]),
        .stall(st[1]), .flush(fl[1]),
        .stall_count(sc[1]), .flush_count(fc[1])
    );

    hazard_unit #(.LOAD_USE_CYCLES(2), .FLUSH_CYCLES(3),
                  .FWD_EN(0), .CNT_W(4)) u_c (
        .clk(clk), .rst_n(rst_n), .c_instr(c_instr),
        .p1_instr(p1_instr), .p1_reg_write(p1_reg_write),
        .p2_instr(p2_instr), .p2_reg_write(p2_reg_write),
        .br_taken(br_taken), .fwd_a(fa[2]), .fwd_b(fb[2]),
        .stall(st[2]), .flush(fl[2]),
        .stall_count(sc_c), .flush_count(fc_c)
    );

    assign sc[2] = {12'd0, sc_c};
    assign fc[2] = {12'd0, fc_c};

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h want %0h", tag, got, exp);
        end
    endtask

    function automatic bit uses(input logic [31:0] i, input int k);
        logic [6:0] op = i[6:0];
        if (k == 0) return !(op == 7'h37 || op == 7'h17 || op == 7'h6F);
        return op == 7'h33 || op == 7'h23 || op == 7'h63;
    endfunction

    function automatic bit writes(input logic [31:0] i, input logic rw);
        return rw && i[11:7] != 0 && i[6:0] != 7'h23 && i[6:0] != 7'h63;
    endfunction

    // Source choice for one operand of the consumer, in RUN.
    function automatic logic [1:0] src(input int k, input bit fwen,
                                       inout bit haz);
        logic [4:0] rs = (k == 0) ? c_instr[19:15] : c_instr[24:20];
        bit m1 = uses(c_instr, k) && writes(p1_instr, p1_reg_write)
                 && p1_instr[11:7] == rs;
        bit m2 = uses(c_instr, k) && writes(p2_instr, p2_reg_write)
                 && p2_instr[11:7] == rs;
        if (!fwen) begin
            if (m1 || m2) haz = 1;
            return 2'd0;
        end
        if (m1) begin
            if (p1_instr[6:0] == 7'h03) begin
                haz = 1;
                return 2'd0;
            end
            return 2'd1;
        end
        if (m2) return 2'd2;
        return 2'd0;
    endfunction

    task automatic settle();
        @(negedge clk);
        for (int i = 0; i < 3; i++) begin
            logic [1:0] ea = 0, eb = 0;
            bit hz = 0, es = 0, ef = 0;
            logic [1:0] ra = src(0, FW[i] != 0, hz);
            logic [1:0] rb = src(1, FW[i] != 0, hz);
            if (rst_n) begin
                if (rem_f[i] > 0) ef = 1;
                else if (rem_s[i] > 0) begin
                    if (br_taken) ef = 1; else es = 1;
                end else begin
                    ea = ra;
                    eb = rb;
                    if (br_taken) ef = 1; else es = hz;
                end
            end
            e_st[i] = es;
            e_fl[i] = ef;
            e_hz[i] = hz;
            chk($sformatf("u%0d.fwd_a", i), fa[i], ea);
            chk($sformatf("u%0d.fwd_b", i), fb[i], eb);
            chk($sformatf("u%0d.stall", i), st[i], es);
            chk($sformatf("u%0d.flush", i), fl[i], ef);
            chk($sformatf("u%0d.stall_count", i), sc[i], ms[i]);
            chk($sformatf("u%0d.flush_count", i), fc[i], mf[i]);
        end
    endtask

    task automatic advance();
        @(posedge clk);
        for (int i = 0; i < 3; i++) begin
            int top = (1 << CW[i]) - 1;
            if (!rst_n) begin
                rem_s[i] = 0;
                rem_f[i] = 0;
                ms[i] = 0;
                mf[i] = 0;
            end else begin
                if (e_st[i] && ms[i] < top) ms[i]++;
                if (e_fl[i] && mf[i] < top) mf[i]++;
                if (br_taken) begin
                    rem_f[i] = FL[i] - 1;
                    rem_s[i] = 0;
                end else if (rem_f[i] > 0) rem_f[i]--;
                else if (rem_s[i] > 0) rem_s[i]--;
                else if (e_hz[i]) rem_s[i] = LU[i] - 1;
            end
        end
        #1;
    endtask

    task automatic drive(input logic [31:0] c, p1, input logic w1,
                         input logic [31:0] p2, input logic w2,
                         input logic br, input logic rn);
        c_instr = c;
        p1_instr = p1;
        p1_reg_write = w1;
        p2_instr = p2;
        p2_reg_write = w2;
        br_taken = br;
        rst_n = rn;
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) begin
            drive(NOP, NOP, 0, NOP, 0, 0, 1);
            settle();
            advance();
        end
    endtask

    task automatic reset_cycle();
        drive(NOP, NOP, 0, NOP, 0, 0, 0);
        settle();
        advance();
    endtask

    function automatic logic [31:0] rand_instr();
        logic [6:0] ops[9] = '{7'h33, 7'h13, 7'h03, 7'h23, 7'h63,
                               7'h6F, 7'h67, 7'h37, 7'h17};
        logic [4:0] rd  = 5'($urandom_range(0, 3));
        logic [4:0] rs1 = 5'($urandom_range(0, 3));
        logic [4:0] rs2 = 5'($urandom_range(0, 3));
        return {7'd0, rs2, rs1, 3'd0, rd, ops[$urandom_range(0, 8)]};
    endfunction

    initial begin
        for (int i = 0; i < 3; i++) begin
            rem_s[i] = 0; rem_f[i] = 0; ms[i] = 0; mf[i] = 0;
        end
        reset_cycle();
        reset_cycle();

        drive(ADD, ADDI1, 1, NOP, 0, 0, 1);
        settle();
        chk("t1.fwd_a", fa[0], 2'b01);
        chk("t1.fwd_b", fb[0], 2'b00);
        chk("t1.stall", st[0], 1'b0);
        advance();

        drive(ADD, ADDI1, 1, ADDI2, 1, 0, 1);
        settle();
        chk("t2.fwd_a", fa[0], 2'b01);
        chk("t2.fwd_b", fb[0], 2'b10);
        advance();
        drive(ADD, ADDI1, 1, ADDI1, 1, 0, 1);
        settle();
        chk("t2.p1_prio", fa[0], 2'b01);
        advance();
        drive(ADD, ADDI0, 1, ADDI1, 1, 0, 1);
        settle();
        chk("t2.rd_x0", fa[0], 2'b10);
        advance();

        reset_cycle();
        drive(ADD, LW1, 1, NOP, 0, 0, 1);
        settle();
        chk("t3.stall0", st[0], 1'b1);
        chk("t3.fwd_a0", fa[0], 2'b00);
        advance();
        drive(ADD, NOP, 0, NOP, 0, 0, 1);
        settle();
        chk("t3.stall1", st[0], 1'b1);
        chk("t3.fwd_a1", fa[0], 2'b00);
        advance();
        settle();
        chk("t3.stall2", st[0], 1'b0);
        chk("t3.count", sc[0], 16'd2);
        advance();

        // Second pulse lands on flush cycle 2 and restarts the count,
        // giving one more cycle after it: three flush cycles in total.
        idle(2);
        reset_cycle();
        drive(NOP, NOP, 0, NOP, 0, 1, 1);
        settle();
        chk("t4.flush0", fl[0], 1'b1);
        advance();
        settle();
        chk("t4.flush1", fl[0], 1'b1);
        advance();
        drive(NOP, NOP, 0, NOP, 0, 0, 1);
        settle();
        chk("t4.flush2", fl[0], 1'b1);
        advance();
        settle();
        chk("t4.flush3", fl[0], 1'b0);
        chk("t4.count", fc[0], 16'd3);
        advance();

        idle(4);
        drive(ADD, LW1, 1, NOP, 0, 0, 1);
        settle();
        chk("t5.stall0", st[1], 1'b1);
        advance();
        drive(ADD, NOP, 0, NOP, 0, 1, 1);
        settle();
        chk("t5.stall1", st[1], 1'b0);
        chk("t5.flush1", fl[1], 1'b1);
        advance();
        drive(ADD, NOP, 0, NOP, 0, 0, 1);
        settle();
        chk("t5.stall2", st[1], 1'b0);
        chk("t5.flush2", fl[1], 1'b0);
        advance();

        idle(4);
        drive(NOP, NOP, 0, NOP, 0, 1, 1);
        settle();
        chk("t6.flush0", fl[2], 1'b1);
        advance();
        drive(NOP, NOP, 0, NOP, 0, 0, 0);
        settle();
        chk("t6.gated", fl[2], 1'b0);
        advance();
        drive(NOP, NOP, 0, NOP, 0, 0, 1);
        settle();
        chk("t6.flush_after", fl[2], 1'b0);
        chk("t6.fcount", fc[2], 16'd0);
        chk("t6.scount", sc[2], 16'd0);
        advance();

        drive(ADD, ADDI1, 1, NOP, 0, 0, 1);
        settle();
        chk("t6.nofwd_a", fa[2], 2'b00);
        chk("t6.nofwd_stall0", st[2], 1'b1);
        advance();
        drive(ADD, NOP, 0, NOP, 0, 0, 1);
        settle();
        chk("t6.nofwd_stall1", st[2], 1'b1);
        advance();
        settle();
        chk("t6.nofwd_stall2", st[2], 1'b0);
        advance();

        for (int n = 0; n < 2000; n++) begin
            drive(rand_instr(), rand_instr(), 1'($urandom_range(0, 1)),
                  rand_instr(), 1'($urandom_range(0, 1)),
                  $urandom_range(0, 7) == 0,
                  $urandom_range(0, 99) != 0);
            settle();
            advance();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
